// File: rtl/rf_access_arbiter.sv
// Two-port round-robin arbiter serialising SPI-host and sequencer accesses onto a
// single-port register file; all outputs are registered.
module rf_access_arbiter #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic              rf_re_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    input  logic [DATA_W-1:0] rf_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    // Counter is 4 bits wide, so RD_LAT must stay within 1..15.
    localparam logic [3:0] LAT_INIT = 4'(RD_LAT);

    state_t            state;
    logic              rr;
    logic              owner;
    logic              is_write;
    logic [3:0]        cnt;

    logic              pick;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;

    always_comb begin
        pick       = 1'b0;
        pick_we    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        if (req_i == 2'b10) begin
            pick = 1'b1;
        end else if (req_i == 2'b11) begin
            pick = rr;
        end
        if (pick) begin
            pick_we    = we_i[1];
            pick_addr  = addr1_i;
            pick_wdata = wdata1_i;
        end else begin
            pick_we    = we_i[0];
            pick_addr  = addr0_i;
            pick_wdata = wdata0_i;
        end
    end

    // The RF strobe registers double as the latched address/data of the grant.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state      <= S_IDLE;
            rr         <= 1'b0;
            owner      <= 1'b0;
            is_write   <= 1'b0;
            cnt        <= '0;
            ack_o      <= '0;
            rdata_o    <= '0;
            busy_o     <= 1'b0;
            rf_re_o    <= 1'b0;
            rf_we_o    <= 1'b0;
            rf_addr_o  <= '0;
            rf_wdata_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ack_o   <= '0;
                    rdata_o <= '0;
                    if (|req_i) begin
                        owner     <= pick;
                        rr        <= ~pick;
                        is_write  <= pick_we;
                        busy_o    <= 1'b1;
                        rf_addr_o <= pick_addr;
                        rf_we_o   <= pick_we;
                        rf_re_o   <= ~pick_we;
                        rf_wdata_o <= pick_we ? pick_wdata : '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rf_re_o    <= 1'b0;
                    rf_we_o    <= 1'b0;
                    rf_addr_o  <= '0;
                    rf_wdata_o <= '0;
                    if (is_write) begin
                        ack_o   <= owner ? 2'b10 : 2'b01;
                        rdata_o <= '0;
                        state   <= S_ACK;
                    end else begin
                        cnt   <= LAT_INIT;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt     <= '0;
                        rdata_o <= rf_rdata_i;
                        ack_o   <= owner ? 2'b10 : 2'b01;
                        state   <= S_ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    ack_o   <= '0;
                    rdata_o <= '0;
                    busy_o  <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with RD_LAT=2 and a small RF model whose
// unwritten locations read back as addr ^ 0x39.
module tb_rf_access_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] req = '0;
    logic [1:0] we = '0;
    logic [6:0] addr0 = '0;
    logic [7:0] wdata0 = '0;
    logic [6:0] addr1 = '0;
    logic [7:0] wdata1 = '0;
    logic [1:0] ack;
    logic [7:0] rdata;
    logic       busy;
    logic       rf_re;
    logic       rf_we;
    logic [6:0] rf_addr;
    logic [7:0] rf_wdata;
    logic [7:0] rf_rdata;

    int total = 0;
    int bad = 0;

    rf_access_arbiter #(.ADDR_W(7), .DATA_W(8), .RD_LAT(2)) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst_n),
        .req_i     (req),
        .we_i      (we),
        .addr0_i   (addr0),
        .wdata0_i  (wdata0),
        .addr1_i   (addr1),
        .wdata1_i  (wdata1),
        .ack_o     (ack),
        .rdata_o   (rdata),
        .busy_o    (busy),
        .rf_re_o   (rf_re),
        .rf_we_o   (rf_we),
        .rf_addr_o (rf_addr),
        .rf_wdata_o(rf_wdata),
        .rf_rdata_i(rf_rdata)
    );

    always #5 clk = ~clk;

    // RF model: two-stage read pipeline, data present only RD_LAT cycles after re.
    bit   [7:0] mem [128];
    bit         written [128];
    logic [7:0] s1 = '0;
    logic [7:0] s2 = '0;

    always @(posedge clk) begin
        if (rf_we) begin
            mem[rf_addr]     <= rf_wdata;
            written[rf_addr] <= 1'b1;
        end
        if (rf_re) s1 <= written[rf_addr] ? mem[rf_addr] : ({1'b0, rf_addr} ^ 8'h39);
        else       s1 <= '0;
        s2 <= s1;
    end
    assign rf_rdata = s2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_ack(input int max_cyc, output logic [1:0] who,
                            output logic [7:0] data, output int n);
        who  = '0;
        data = '0;
        n    = 0;
        while (n < max_cyc) begin
            tick();
            n++;
            if (ack != 2'b00) begin
                who  = ack;
                data = rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (ack !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b want=00", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if ({rf_re, rf_we} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b want=00", {rf_re, rf_we}); end
        total++; if ({rf_addr, rf_wdata, rdata} !== 23'd0) begin bad++; $display("FAIL reset_data got=%h want=0", {rf_addr, rf_wdata, rdata}); end
        rst_n = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_p0_write();
        req = 2'b01; we = 2'b01; addr0 = 7'h12; wdata0 = 8'hA5;
        tick();
        total++; if ({rf_we, rf_re} !== 2'b10) begin bad++; $display("FAIL wr_issue_strobes got=%b want=10", {rf_we, rf_re}); end
        total++; if (rf_addr !== 7'h12) begin bad++; $display("FAIL wr_issue_addr got=%h want=12", rf_addr); end
        total++; if (rf_wdata !== 8'hA5) begin bad++; $display("FAIL wr_issue_data got=%h want=a5", rf_wdata); end
        total++; if (ack !== 2'b00 || busy !== 1'b1) begin bad++; $display("FAIL wr_issue_ack got=%b/%b want=00/1", ack, busy); end
        tick();
        total++; if (ack !== 2'b01) begin bad++; $display("FAIL wr_ack got=%b want=01", ack); end
        total++; if ({rf_we, rf_re, rf_addr, rf_wdata} !== 17'd0) begin bad++; $display("FAIL wr_ack_rf got=%h want=0", {rf_we, rf_re, rf_addr, rf_wdata}); end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL wr_ack_rdata got=%h want=00", rdata); end
        req = 2'b00;
        tick();
        total++; if (ack !== 2'b00 || busy !== 1'b0 || rf_re !== 1'b0) begin bad++; $display("FAIL wr_done got=%b/%b/%b want=00/0/0", ack, busy, rf_re); end
        total++; if (mem[7'h12] !== 8'hA5) begin bad++; $display("FAIL wr_rf_content got=%h want=a5", mem[7'h12]); end
    endtask

    task automatic test_p1_read();
        req = 2'b10; we = 2'b00; addr1 = 7'h05;
        tick();
        total++; if ({rf_re, rf_we} !== 2'b10 || rf_addr !== 7'h05) begin bad++; $display("FAIL rd_issue got=%b addr=%h want=10 addr=05", {rf_re, rf_we}, rf_addr); end
        total++; if (rf_wdata !== 8'h00) begin bad++; $display("FAIL rd_issue_wdata got=%h want=00", rf_wdata); end
        for (int c = 2; c <= 3; c++) begin
            tick();
            total++; if (ack !== 2'b00 || rdata !== 8'h00 || rf_re !== 1'b0 || rf_addr !== 7'h00) begin
                bad++; $display("FAIL rd_wait_c%0d got ack=%b rdata=%h re=%b addr=%h want 00/00/0/00", c, ack, rdata, rf_re, rf_addr);
            end
        end
        tick();
        total++; if (ack !== 2'b10) begin bad++; $display("FAIL rd_ack got=%b want=10", ack); end
        total++; if (rdata !== 8'h3C) begin bad++; $display("FAIL rd_data got=%h want=3c", rdata); end
        req = 2'b00;
        tick();
        total++; if (ack !== 2'b00 || rdata !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL rd_done got=%b/%h/%b want=00/00/0", ack, rdata, busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] who;
        logic [7:0] d;
        int         n;
        do_reset();
        we = 2'b11; addr0 = 7'h20; wdata0 = 8'h11; addr1 = 7'h21; wdata1 = 8'h22;
        req = 2'b11;
        tick();
        total++; if (rf_we !== 1'b1 || rf_addr !== 7'h20 || rf_wdata !== 8'h11) begin bad++; $display("FAIL rr_first_issue got=%b %h %h want=1 20 11", rf_we, rf_addr, rf_wdata); end
        tick();
        total++; if (ack !== 2'b01) begin bad++; $display("FAIL rr_first_ack got=%b want=01", ack); end
        addr0 = 7'h30; wdata0 = 8'h33;
        tick();
        tick();
        total++; if (rf_we !== 1'b1 || rf_addr !== 7'h21 || rf_wdata !== 8'h22) begin bad++; $display("FAIL rr_second_issue got=%b %h %h want=1 21 22", rf_we, rf_addr, rf_wdata); end
        tick();
        total++; if (ack !== 2'b10) begin bad++; $display("FAIL rr_second_ack got=%b want=10", ack); end
        req = 2'b01;
        wait_ack(10, who, d, n);
        total++; if (who !== 2'b01 || n !== 3) begin bad++; $display("FAIL rr_third got=%b after %0d want=01 after 3", who, n); end
        total++; if (mem[7'h30] !== 8'h33) begin bad++; $display("FAIL rr_third_content got=%h want=33", mem[7'h30]); end
        req = 2'b00;
        tick();
        req = 2'b10; we = 2'b00; addr1 = 7'h05;
        wait_ack(10, who, d, n);
        total++; if (who !== 2'b10 || d !== 8'h3C || n !== 4) begin bad++; $display("FAIL rr_p1_alone got=%b %h after %0d want=10 3c after 4", who, d, n); end
        req = 2'b00;
        tick();
        we = 2'b11; addr0 = 7'h22; wdata0 = 8'h44; addr1 = 7'h23; wdata1 = 8'h55;
        req = 2'b11;
        tick();
        total++; if (rf_addr !== 7'h22) begin bad++; $display("FAIL rr_after_single got=%h want=22", rf_addr); end
        tick();
        total++; if (ack !== 2'b01) begin bad++; $display("FAIL rr_after_single_ack got=%b want=01", ack); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int cnt0 = 0;
        int cnt1 = 0;
        int cyc  = 0;
        do_reset();
        we = 2'b11; addr0 = 7'h40; wdata0 = 8'h50; addr1 = 7'h41; wdata1 = 8'h51;
        req = 2'b11;
        while (acks < 8 && cyc < 40) begin
            tick();
            cyc++;
            total++; if (rf_re !== 1'b0) begin bad++; $display("FAIL b2b_re cyc=%0d got=1 want=0", cyc); end
            if (rf_we) begin
                total++; if (rf_addr !== ((acks % 2) ? 7'h41 : 7'h40)) begin bad++; $display("FAIL b2b_addr cyc=%0d got=%h want=%h", cyc, rf_addr, (acks % 2) ? 7'h41 : 7'h40); end
            end else begin
                total++; if (rf_addr !== 7'h00 || rf_wdata !== 8'h00) begin bad++; $display("FAIL b2b_idle_bus cyc=%0d got=%h/%h want=00/00", cyc, rf_addr, rf_wdata); end
            end
            if (ack != 2'b00) begin
                total++; if (ack !== ((acks % 2) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL b2b_order n=%0d got=%b want=%b", acks, ack, (acks % 2) ? 2'b10 : 2'b01); end
                if (ack == 2'b01) cnt0++;
                if (ack == 2'b10) cnt1++;
                acks++;
                if (acks == 8) req = 2'b00;
            end
        end
        total++; if (acks !== 8 || cyc !== 23) begin bad++; $display("FAIL b2b_count got=%0d acks in %0d cyc want=8 in 23", acks, cyc); end
        total++; if (cnt0 !== 4 || cnt1 !== 4) begin bad++; $display("FAIL b2b_split got=%0d/%0d want=4/4", cnt0, cnt1); end
        tick();
        total++; if (busy !== 1'b0 || ack !== 2'b00) begin bad++; $display("FAIL b2b_end got=%b/%b want=0/00", busy, ack); end
    endtask

    task automatic test_reset_in_wait();
        logic [1:0] who;
        logic [7:0] d;
        int         n;
        req = 2'b01; we = 2'b00; addr0 = 7'h33;
        tick();
        total++; if (rf_re !== 1'b1) begin bad++; $display("FAIL rst_wait_issue got=%b want=1", rf_re); end
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_wait_busy got=%b want=1", busy); end
        #2;
        rst_n = 1'b0;
        req   = 2'b00;
        #1;
        total++; if ({ack, busy, rf_re, rf_we, rf_addr, rf_wdata, rdata} !== 29'd0) begin
            bad++; $display("FAIL rst_async got=%h want=0", {ack, busy, rf_re, rf_we, rf_addr, rf_wdata, rdata});
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (ack !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL rst_hold c=%0d got=%b/%b want=00/0", c, ack, busy); end
        end
        rst_n = 1'b1;
        tick();
        total++; if (ack !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL rst_release got=%b/%b want=00/0", ack, busy); end
        req = 2'b01;
        wait_ack(12, who, d, n);
        total++; if (who !== 2'b01 || d !== 8'h0A || n !== 4) begin bad++; $display("FAIL rst_rerequest got=%b %h after %0d want=01 0a after 4", who, d, n); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_addr_change();
        logic [1:0] who;
        logic [7:0] d;
        int         n;
        req = 2'b01; we = 2'b00; addr0 = 7'h44;
        tick();
        total++; if (rf_addr !== 7'h44) begin bad++; $display("FAIL latch_issue_addr got=%h want=44", rf_addr); end
        tick();
        addr0 = 7'h45;
        we    = 2'b01;
        wait_ack(10, who, d, n);
        total++; if (who !== 2'b01 || n !== 2) begin bad++; $display("FAIL latch_ack got=%b after %0d want=01 after 2", who, n); end
        total++; if (d !== 8'h7D) begin bad++; $display("FAIL latch_data got=%h want=7d", d); end
        total++; if (written[7'h45] !== 1'b0) begin bad++; $display("FAIL latch_no_write got=%b want=0", written[7'h45]); end
        req = 2'b00;
        we  = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_p0_write();
        test_p1_read();
        test_round_robin();
        test_back_to_back();
        test_reset_in_wait();
        test_addr_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
